cache_arbiter: RTL and testbench
================================

CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 SHALL have parameter LINE_W, default 256, meaning cache line / memory burst width in bits.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning byte address width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port i_read  input  1  I-cache line-fill request, held until i_resp.
REQ-006 SHALL have port i_address  input  ADDR_W  I-cache line address.
REQ-007 SHALL have port i_rdata  output  LINE_W  line data returned to the I-cache.
REQ-008 SHALL have port i_resp  output  1  one-cycle I-cache completion strobe.
REQ-009 SHALL have port d_read  input  1  D-cache line-fill request, held until d_resp.
REQ-010 SHALL have port d_write  input  1  D-cache writeback request, held until d_resp.
REQ-011 SHALL have port d_address  input  ADDR_W  D-cache line address.
REQ-012 SHALL have port d_wdata  input  LINE_W  D-cache writeback data.
REQ-013 SHALL have port d_rdata  output  LINE_W  line data returned to the D-cache.
REQ-014 SHALL have port d_resp  output  1  one-cycle D-cache completion strobe.
REQ-015 SHALL have port pmem_read, pmem_write  output  1 each  physical memory commands.
REQ-016 SHALL have port pmem_address  output  ADDR_W  registered physical memory address.
REQ-017 SHALL have port pmem_wdata  output  LINE_W  registered physical memory write data.
REQ-018 SHALL have port pmem_rdata  input  LINE_W  physical memory read data, valid with pmem_resp.
REQ-019 SHALL have port pmem_resp  input  1  physical memory completion strobe.
REQ-020 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-021 SHALL implement FSM states IDLE, SERVE_I, SERVE_D.
REQ-022 IDLE: only i_read -> SERVE_I; only D request -> SERVE_D; neither -> stay in IDLE.
REQ-023 IDLE, both requesting: SHALL grant the requester opposite to register last_grant.
REQ-024 last_grant SHALL update to the granted side on every grant.
REQ-025 On grant, the block SHALL latch address and kind (read/write); for a D write it SHALL also latch d_wdata into the pmem_address / pmem_wdata / op registers.
REQ-026 Request changes after grant SHALL NOT affect the in-flight transaction.
REQ-027 SERVE_I SHALL drive pmem_read=1 and pmem_write=0.
REQ-028 SERVE_D SHALL drive exactly one of pmem_read / pmem_write per the latched kind.
REQ-029 d_read and d_write both high at grant SHALL be treated as a write.
REQ-030 pmem_read/pmem_write SHALL assert in the first cycle after the grant edge.
REQ-031 pmem_read/pmem_write SHALL remain asserted until the cycle in which pmem_resp=1.
REQ-032 In SERVE_x with pmem_resp=1: x_resp=1 combinationally that cycle, and the FSM returns to IDLE next edge.
REQ-033 Minimum spacing SHALL be one IDLE cycle between back-to-back transactions.
REQ-034 i_rdata and d_rdata SHALL both pass pmem_rdata through combinationally.
REQ-035 i_resp SHALL never assert outside SERVE_I; d_resp SHALL never assert outside SERVE_D.
REQ-036 pmem_resp in IDLE SHALL be ignored: no resp forwarded, no state change.
REQ-037 Latency SHALL be: request at IDLE edge N -> pmem command in cycle N+1 -> resp in the same cycle as pmem_resp.
REQ-038 i_resp and d_resp SHALL never be simultaneously high.

Reset
REQ-039 rst=1 SHALL immediately force state IDLE, last_grant=I, and pmem_read=pmem_write=0.
REQ-040 rst=1 SHALL immediately force i_resp=d_resp=0, busy=0, and pmem_address=0, pmem_wdata=0.
REQ-041 Reset mid-transaction SHALL abandon it: no resp is issued, and a pmem_resp after reset release in IDLE is ignored.

Verification
REQ-042 Single I fill: i_read, i_address=0x0000_0040; memory responds after 5 cycles with 0xA5 pattern -> pmem_read high 5 cycles, i_resp 1 cycle, i_rdata=pattern, d_resp=0.
REQ-043 D writeback: d_write, d_address=0x1000_0000, d_wdata=0xDEAD… -> pmem_write=1, pmem_address/pmem_wdata match; d_address changed mid-transaction -> pmem_address unchanged.
REQ-044 Contention after reset: i_read and d_read together -> D served first (last_grant=I), then I after one IDLE cycle; third contention -> D again.
REQ-045 Spurious pmem_resp in IDLE -> no resp, busy stays 0.
REQ-046 rst asserted 2 cycles into SERVE_D -> pmem_write drops same cycle, no d_resp; post-release pmem_resp ignored, then new i_read served normally.
REQ-047 d_read and d_write both asserted -> pmem_write=1, pmem_read=0.

Source files
------------

// File: rtl/cache_arbiter.sv
// Arbitrates I-cache fills and D-cache fills/writebacks onto one physical memory port.
// Contention is resolved round-robin against the side granted last.
module cache_arbiter #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_e;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    state_e              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                op_write_q, op_write_d;
    logic                pmem_read_q, pmem_read_d;
    logic                pmem_write_q, pmem_write_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LINE_W-1:0]   wdata_q, wdata_d;
    logic                grant_i_s;
    logic                grant_d_s;
    logic                d_req_s;

    // State and datapath registers; reset abandons any in-flight transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_I;
            op_write_q   <= 1'b0;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_write_q   <= op_write_d;
            pmem_read_q  <= pmem_read_d;
            pmem_write_q <= pmem_write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    // Next-state and grant decision; on contention the side not granted last wins.
    always_comb begin
        state_d   = state_q;
        grant_i_s = 1'b0;
        grant_d_s = 1'b0;
        d_req_s   = d_read | d_write;
        case (state_q)
            IDLE: begin
                if (i_read && d_req_s) begin
                    if (last_grant_q == GRANT_I) begin
                        grant_d_s = 1'b1;
                    end else begin
                        grant_i_s = 1'b1;
                    end
                end else if (i_read) begin
                    grant_i_s = 1'b1;
                end else if (d_req_s) begin
                    grant_d_s = 1'b1;
                end else begin
                    grant_i_s = 1'b0;
                end
                if (grant_i_s) begin
                    state_d = SERVE_I;
                end else if (grant_d_s) begin
                    state_d = SERVE_D;
                end else begin
                    state_d = IDLE;
                end
            end
            SERVE_I, SERVE_D: begin
                if (pmem_resp) begin
                    state_d = IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Latch the granted transaction so later request changes cannot disturb it.
    always_comb begin
        last_grant_d = last_grant_q;
        op_write_d   = op_write_q;
        pmem_read_d  = pmem_read_q;
        pmem_write_d = pmem_write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        if (grant_i_s) begin
            last_grant_d = GRANT_I;
            op_write_d   = 1'b0;
            pmem_read_d  = 1'b1;
            pmem_write_d = 1'b0;
            addr_d       = i_address;
        end else if (grant_d_s) begin
            // A simultaneous read and write is treated as a writeback.
            last_grant_d = GRANT_D;
            op_write_d   = d_write;
            pmem_read_d  = ~d_write;
            pmem_write_d = d_write;
            addr_d       = d_address;
            if (d_write) begin
                wdata_d = d_wdata;
            end else begin
                wdata_d = wdata_q;
            end
        end else if ((state_q != IDLE) && pmem_resp) begin
            pmem_read_d  = 1'b0;
            pmem_write_d = 1'b0;
        end else begin
            pmem_read_d  = pmem_read_q;
            pmem_write_d = pmem_write_q;
        end
    end

    // Completion strobes are combinational so they land in the pmem_resp cycle.
    always_comb begin
        i_resp       = (state_q == SERVE_I) && pmem_resp;
        d_resp       = (state_q == SERVE_D) && pmem_resp;
        busy         = (state_q != IDLE);
        i_rdata      = pmem_rdata;
        d_rdata      = pmem_rdata;
        pmem_read    = pmem_read_q;
        pmem_write   = pmem_write_q;
        pmem_address = addr_q;
        pmem_wdata   = wdata_q;
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter with a response scoreboard and a cycle-counting memory model.
module tb_cache_arbiter;

    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;

    logic              clk;
    logic              rst;
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;
    logic              busy;

    typedef struct {
        bit                is_d;
        logic [LINE_W-1:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;

    cache_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, LINE_W'(busy), LINE_W'(1'b0));
        check({tag, "_pread"}, LINE_W'(pmem_read), LINE_W'(1'b0));
        check({tag, "_pwrite"}, LINE_W'(pmem_write), LINE_W'(1'b0));
        check({tag, "_iresp"}, LINE_W'(i_resp), LINE_W'(1'b0));
        check({tag, "_dresp"}, LINE_W'(d_resp), LINE_W'(1'b0));
    endtask

    // Grant edge, then lat command cycles with pmem_resp in the last one.
    task automatic serve(input bit side_d, input bit exp_wr, input logic [ADDR_W-1:0] exp_addr,
                         input logic [LINE_W-1:0] exp_wdata, input int lat,
                         input logic [LINE_W-1:0] rdata, input bit scramble);
        int   cmd_cycles;
        exp_t e;
        cmd_cycles = 0;
        tick();
        for (int k = 1; k <= lat; k++) begin
            if (pmem_read || pmem_write) cmd_cycles++;
            check("pmem_read", LINE_W'(pmem_read), LINE_W'(!exp_wr));
            check("pmem_write", LINE_W'(pmem_write), LINE_W'(exp_wr));
            check("pmem_address", LINE_W'(pmem_address), LINE_W'(exp_addr));
            check("busy", LINE_W'(busy), LINE_W'(1'b1));
            if (exp_wr) check("pmem_wdata", pmem_wdata, exp_wdata);
            if (scramble && k == 2) begin
                d_address = ~d_address;
                d_wdata   = ~d_wdata;
            end
            if (k == lat) begin
                pmem_resp  = 1'b1;
                pmem_rdata = rdata;
                #1;
                check("i_resp", LINE_W'(i_resp), LINE_W'(!side_d));
                check("d_resp", LINE_W'(d_resp), LINE_W'(side_d));
                check("i_rdata", i_rdata, rdata);
                check("d_rdata", d_rdata, rdata);
                if (i_resp || d_resp) begin
                    tests++;
                    assert (sb_q.size() > 0) else begin
                        fails++;
                        $error("FAIL sb_underflow: observed an unexpected response, required none");
                    end
                    if (sb_q.size() > 0) begin
                        e = sb_q.pop_front();
                        check("sb_side", LINE_W'(d_resp), LINE_W'(e.is_d));
                        check("sb_data", d_resp ? d_rdata : i_rdata, e.data);
                    end
                end
            end else begin
                tick();
            end
        end
        check("cmd_cycles", LINE_W'(cmd_cycles), LINE_W'(lat));
        tick();
        pmem_resp = 1'b0;
        if (side_d) begin
            d_read  = 1'b0;
            d_write = 1'b0;
        end else begin
            i_read = 1'b0;
        end
        check_idle_outputs("gap");
    endtask

    initial begin
        logic [LINE_W-1:0] pat_a5;
        logic [LINE_W-1:0] pat_dead;
        pat_a5   = {32{8'hA5}};
        pat_dead = {8{32'hDEADBEEF}};

        rst = 1'b1;
        i_read = 1'b0; i_address = '0;
        d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0;
        pmem_rdata = '0; pmem_resp = 1'b0;
        tick();
        tick();
        check_idle_outputs("reset");
        check("reset_paddr", LINE_W'(pmem_address), LINE_W'(32'h0));
        check("reset_pwdata", pmem_wdata, {LINE_W{1'b0}});
        rst = 1'b0;
        tick();

        // Spurious memory response while idle.
        pmem_resp = 1'b1;
        pmem_rdata = {8{32'h0BAD_F00D}};
        #1;
        check_idle_outputs("spur");
        tick();
        pmem_resp = 1'b0;
        check_idle_outputs("spur_after");

        // Contention straight after reset: D first, then I after one idle cycle.
        i_read = 1'b1; i_address = 32'h0000_2000;
        d_read = 1'b1; d_address = 32'h0000_3000;
        sb_q.push_back('{1'b1, {8{32'h1111_2222}}});
        sb_q.push_back('{1'b0, {8{32'h3333_4444}}});
        serve(1'b1, 1'b0, 32'h0000_3000, '0, 3, {8{32'h1111_2222}}, 1'b0);
        serve(1'b0, 1'b0, 32'h0000_2000, '0, 2, {8{32'h3333_4444}}, 1'b0);

        // Third contention: last grant was I, so D wins again.
        i_read = 1'b1; i_address = 32'h0000_2040;
        d_read = 1'b1; d_address = 32'h0000_3040;
        sb_q.push_back('{1'b1, {8{32'h5555_6666}}});
        sb_q.push_back('{1'b0, {8{32'h7777_8888}}});
        serve(1'b1, 1'b0, 32'h0000_3040, '0, 1, {8{32'h5555_6666}}, 1'b0);
        serve(1'b0, 1'b0, 32'h0000_2040, '0, 4, {8{32'h7777_8888}}, 1'b0);

        // Single I fill with a five-cycle memory.
        i_read = 1'b1; i_address = 32'h0000_0040;
        sb_q.push_back('{1'b0, pat_a5});
        serve(1'b0, 1'b0, 32'h0000_0040, '0, 5, pat_a5, 1'b0);

        // D writeback; address and data change mid-transaction.
        d_write = 1'b1; d_address = 32'h1000_0000; d_wdata = pat_dead;
        sb_q.push_back('{1'b1, {8{32'h0000_0001}}});
        serve(1'b1, 1'b1, 32'h1000_0000, pat_dead, 4, {8{32'h0000_0001}}, 1'b1);

        // Read and write together behave as a write.
        d_read = 1'b1; d_write = 1'b1; d_address = 32'h2000_0080; d_wdata = {8{32'hCAFE_0123}};
        sb_q.push_back('{1'b1, {8{32'h0000_0002}}});
        serve(1'b1, 1'b1, 32'h2000_0080, {8{32'hCAFE_0123}}, 2, {8{32'h0000_0002}}, 1'b0);

        // Reset two cycles into a D writeback abandons it.
        d_write = 1'b1; d_address = 32'h3000_0000; d_wdata = {8{32'h1234_5678}};
        tick();
        check("mid_pwrite", LINE_W'(pmem_write), LINE_W'(1'b1));
        tick();
        rst = 1'b1;
        #1;
        check_idle_outputs("mid_rst");
        check("mid_rst_paddr", LINE_W'(pmem_address), LINE_W'(32'h0));
        d_write = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        pmem_resp = 1'b1;
        pmem_rdata = {8{32'h9999_9999}};
        #1;
        check_idle_outputs("post_rst_spur");
        tick();
        pmem_resp = 1'b0;
        check_idle_outputs("post_rst_idle");

        i_read = 1'b1; i_address = 32'h0000_0100;
        sb_q.push_back('{1'b0, {8{32'hABCD_EF01}}});
        serve(1'b0, 1'b0, 32'h0000_0100, '0, 3, {8{32'hABCD_EF01}}, 1'b0);

        check("sb_drained", LINE_W'(sb_q.size()), LINE_W'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
